// File: rtl/u_mask_scan.sv
// ---------------------------------------------------------------------------
// u_mask_scan
//
// Sequential run-length scanner. Accepts a W-bit vector over a valid/ready
// handshake and reports how many consecutive bits, counted from the selected
// end, equal MATCH_BIT. C bits are examined per SCAN cycle; the scan stops
// at the first chunk that contains a mismatch.
//
// Parameters:
//   W          input vector width (W >= 1)
//   C          bits examined per SCAN cycle (1 <= C <= W, W % C == 0)
//   MATCH_BIT  bit value being counted
//   LSB        1: count upward from bit 0; 0: count downward from bit W-1
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   i_in_vld   input vector valid
//   o_in_rdy   block can accept a vector (IDLE)
//   i_in_x     vector to scan, sampled on i_in_vld & o_in_rdy
//   o_out_vld  result valid (DONE)
//   i_out_rdy  consumer accepts result
//   o_out_cnt  run length of MATCH_BIT, 0..W
//   o_out_all  o_out_cnt == W
// ---------------------------------------------------------------------------
module u_mask_scan #(
  parameter int   W         = 32,
  parameter int   C         = 4,
  parameter logic MATCH_BIT = 1'b1,
  parameter logic LSB       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_in_vld,
  output logic                     o_in_rdy,
  input  logic [W-1:0]             i_in_x,
  output logic                     o_out_vld,
  input  logic                     i_out_rdy,
  output logic [$clog2(W+1)-1:0]   o_out_cnt,
  output logic                     o_out_all
);

  localparam int N  = W / C;
  localparam int CW = $clog2(W + 1);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(C + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (C < 1 || C > W || (W % C) != 0) begin : g_bad_cfg
      $error("u_mask_scan: C must satisfy 1 <= C <= W and divide W");
    end
  endgenerate

  logic [1:0]    state;
  logic [W-1:0]  x_oriented;
  logic [W-1:0]  sh;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic          all_q;
  logic [LW-1:0] lead;
  logic          run;
  logic          chunk_all;

  // Orient the input so the scan always starts at index 0 of the shift
  // register, whichever end is being counted from.
  generate
    if (LSB) begin : g_lsb
      assign x_oriented = i_in_x;
    end else begin : g_msb
      for (genvar i = 0; i < W; i++) begin : g_rev
        assign x_oriented[i] = i_in_x[W-1-i];
      end
    end
  endgenerate

  // Matching bits before the first mismatch in the current chunk (0..C).
  // NOTE: every variable written here gets a default before the loop, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = 0; i < C; i++) begin
      if (run && (sh[i] == MATCH_BIT)) begin
        lead = lead + LW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  assign chunk_all = (lead == LW'(C));

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      all_q <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_in_vld) begin
            state <= S_SCAN;
            cnt   <= '0;
            all_q <= 1'b0;
            k     <= '0;
          end
        end
        S_SCAN: begin
          cnt <= cnt + CW'(lead);
          if (!chunk_all) begin
            all_q <= 1'b0;
            state <= S_DONE;
          end else if (k == KW'(N - 1)) begin
            all_q <= 1'b1;
            state <= S_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (i_out_rdy) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the data shift register carries no reset; it is always loaded on
  // acceptance before any of its bits are looked at.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && i_in_vld) begin
      sh <= x_oriented;
    end else if (state == S_SCAN) begin
      sh <= sh >> C;
    end
  end

  assign o_in_rdy  = (state == S_IDLE);
  assign o_out_vld = (state == S_DONE);
  assign o_out_cnt = cnt;
  assign o_out_all = all_q;

endmodule

// File: tb/tb_u_mask_scan.sv
// ---------------------------------------------------------------------------
// tb_u_mask_scan
//
// Three W=8, C=2 instances cover the counting variants:
//   d0: MATCH_BIT=1, LSB=1   d1: MATCH_BIT=0, LSB=1   d2: MATCH_BIT=1, LSB=0
// A transaction-level model predicts run length and result timing from the
// handshakes; one compare process checks every instance on every negedge.
// Directed vectors additionally carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_u_mask_scan;

  localparam int W = 8;
  localparam int C = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld  [3];
  logic       in_rdy  [3];
  logic [7:0] in_x    [3];
  logic       out_vld [3];
  logic       out_rdy [3];
  logic [3:0] out_cnt [3];
  logic       out_all [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  u_mask_scan #(.W(W), .C(C), .MATCH_BIT(1'b1), .LSB(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .i_in_vld(in_vld[0]), .o_in_rdy(in_rdy[0]), .i_in_x(in_x[0]),
    .o_out_vld(out_vld[0]), .i_out_rdy(out_rdy[0]),
    .o_out_cnt(out_cnt[0]), .o_out_all(out_all[0])
  );

  u_mask_scan #(.W(W), .C(C), .MATCH_BIT(1'b0), .LSB(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .i_in_vld(in_vld[1]), .o_in_rdy(in_rdy[1]), .i_in_x(in_x[1]),
    .o_out_vld(out_vld[1]), .i_out_rdy(out_rdy[1]),
    .o_out_cnt(out_cnt[1]), .o_out_all(out_all[1])
  );

  u_mask_scan #(.W(W), .C(C), .MATCH_BIT(1'b1), .LSB(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .i_in_vld(in_vld[2]), .o_in_rdy(in_rdy[2]), .i_in_x(in_x[2]),
    .o_out_vld(out_vld[2]), .i_out_rdy(out_rdy[2]),
    .o_out_cnt(out_cnt[2]), .o_out_all(out_all[2])
  );

  bit cfg_m [3] = '{1'b1, 1'b0, 1'b1};
  bit cfg_l [3] = '{1'b1, 1'b1, 1'b0};

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Run length from the chosen end: walk positions while they equal m.
  function automatic int ref_cnt(input logic [7:0] x, input bit m, input bit lsb);
    int c = 0;
    while (c < W && ((lsb ? x[c] : x[W-1-c]) == m)) c++;
    return c;
  endfunction

  // SCAN cycles needed: every chunk if the whole vector matches, otherwise
  // up to and including the chunk holding the first mismatch.
  function automatic int scan_cycles(input int c);
    return (c == W) ? (W / C) : (c / C + 1);
  endfunction

  // Transaction model: busy from acceptance until the result is taken;
  // the result becomes visible after scan_cycles() further edges.
  bit m_busy [3] = '{3{1'b0}};
  bit m_vld  [3] = '{3{1'b0}};
  int m_wait [3] = '{3{0}};
  int m_cnt  [3] = '{3{0}};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_vld[d]  <= 1'b0;
        m_wait[d] <= 0;
      end else if (!m_busy[d]) begin
        if (in_vld[d]) begin
          m_busy[d] <= 1'b1;
          m_cnt[d]  <= ref_cnt(in_x[d], cfg_m[d], cfg_l[d]);
          m_wait[d] <= scan_cycles(ref_cnt(in_x[d], cfg_m[d], cfg_l[d]));
        end
      end else if (!m_vld[d]) begin
        m_wait[d] <= m_wait[d] - 1;
        if (m_wait[d] == 1) m_vld[d] <= 1'b1;
      end else if (out_rdy[d]) begin
        m_busy[d] <= 1'b0;
        m_vld[d]  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("model_in_rdy%0d", d), int'(in_rdy[d]), int'(!m_busy[d]));
        check($sformatf("model_out_vld%0d", d), int'(out_vld[d]), int'(m_vld[d]));
        if (m_vld[d]) begin
          check($sformatf("model_cnt%0d", d), int'(out_cnt[d]), m_cnt[d]);
          check($sformatf("model_all%0d", d), int'(out_all[d]), int'(m_cnt[d] == W));
        end
      end
    end
  end

  // Send one vector, measure cycles from acceptance to o_out_vld, check
  // against literals, then take the result.
  task automatic run(input int d, input logic [7:0] x, input int ec,
                     input int ea, input int el, input string nm);
    int lat;
    @(negedge clk);
    in_x[d]   = x;
    in_vld[d] = 1'b1;
    @(negedge clk);
    in_vld[d] = 1'b0;
    lat = 1;
    while (!out_vld[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, lat, el);
    check({nm, "_cnt"}, int'(out_cnt[d]), ec);
    check({nm, "_all"}, int'(out_all[d]), ea);
    out_rdy[d] = 1'b1;
    @(negedge clk);
    out_rdy[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_vld[d]  = 1'b0;
      in_x[d]    = '0;
      out_rdy[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_in_rdy",  int'(in_rdy[0]),  1);
    check("rst_out_vld", int'(out_vld[0]), 0);
    check("rst_cnt",     int'(out_cnt[0]), 0);
    check("rst_all",     int'(out_all[0]), 0);
    rst = 1'b0;

    run(0, 8'hFF, 8, 1, 5, "d0_ff");
    run(0, 8'h07, 3, 0, 3, "d0_07");
    run(0, 8'h00, 0, 0, 2, "d0_00");
    run(1, 8'hF0, 4, 0, 4, "d1_f0");
    run(1, 8'h00, 8, 1, 5, "d1_00");
    run(2, 8'hE0, 3, 0, 3, "d2_e0");
    run(2, 8'h7F, 0, 0, 2, "d2_7f");
    run(2, 8'hFE, 7, 0, 5, "d2_fe");

    // Backpressure: 8'h15 -> run of 1, result held for 5 cycles while a new
    // vector is offered and must wait for IDLE.
    @(negedge clk);
    in_x[0]   = 8'h15;
    in_vld[0] = 1'b1;
    @(negedge clk);
    in_vld[0] = 1'b0;
    lat = 1;
    while (!out_vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 2);
    in_x[0]   = 8'h0F;
    in_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_vld", int'(out_vld[0]), 1);
      check("bp_hold_cnt", int'(out_cnt[0]), 1);
      check("bp_hold_all", int'(out_all[0]), 0);
      check("bp_hold_rdy", int'(in_rdy[0]),  0);
    end
    out_rdy[0] = 1'b1;
    @(negedge clk);
    out_rdy[0] = 1'b0;
    check("bp_release_vld", int'(out_vld[0]), 0);
    check("bp_release_rdy", int'(in_rdy[0]),  1);
    @(negedge clk);
    in_vld[0] = 1'b0;
    lat = 1;
    while (!out_vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_lat", lat, 4);
    check("bp_next_cnt", int'(out_cnt[0]), 4);
    out_rdy[0] = 1'b1;
    @(negedge clk);
    out_rdy[0] = 1'b0;

    // Reset in the middle of a scan discards the vector.
    @(negedge clk);
    in_x[0]   = 8'hFF;
    in_vld[0] = 1'b1;
    @(negedge clk);
    in_vld[0] = 1'b0;
    check("mid_scan_busy", int'(in_rdy[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_rdy",  int'(in_rdy[0]),  1);
    check("mid_rst_out_vld", int'(out_vld[0]), 0);
    check("mid_rst_cnt",     int'(out_cnt[0]), 0);
    check("mid_rst_all",     int'(out_all[0]), 0);
    rst = 1'b0;
    run(0, 8'h01, 1, 0, 2, "d0_01");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
